// File: rtl/conv_layer_mem_chk.sv
// conv_layer_mem_chk: banked layer memories with expected-image store and self-check scan
module conv_layer_mem_chk #(
  parameter int DW = 20,
  parameter int AW = 12,
  parameter int SW = 3,
  parameter int NBANK = 5,
  parameter logic [NBANK*(AW+1)-1:0] BANK_LEN = {13'd2048, 13'd1024, 13'd1024, 13'd4096, 13'd4096},
  parameter int ERRW = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cwr,
  input  logic [AW-1:0]         caddr_wr,
  input  logic [DW-1:0]         cdata_wr,
  input  logic                  crd,
  input  logic [AW-1:0]         caddr_rd,
  output logic [DW-1:0]         cdata_rd,
  input  logic [SW-1:0]         csel,
  input  logic                  exp_we,
  input  logic [SW-1:0]         exp_sel,
  input  logic [AW-1:0]         exp_addr,
  input  logic [DW-1:0]         exp_data,
  input  logic                  clr,
  input  logic                  chk_start,
  output logic                  chk_busy,
  output logic                  chk_done,
  output logic [NBANK-1:0]      written,
  output logic [NBANK*ERRW-1:0] err_cnt,
  output logic                  first_err_vld,
  output logic [SW-1:0]         first_err_bank,
  output logic [AW-1:0]         first_err_addr,
  output logic                  proto_err
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t st;
  logic [DW-1:0] mem [NBANK][2**AW];
  logic [DW-1:0] expm [NBANK][2**AW];
  logic [NBANK-1:0][ERRW-1:0] cnt;
  logic [SW-1:0] wi, ei, bank, first_b, nxt_b, p_bank;
  logic cwr_ok, crd_ok, exp_ok, first_ok, nxt_ok, issuing, p_vld;
  logic [AW-1:0] addr, p_addr;
  logic [AW:0] len;
  logic [DW-1:0] p_mem, p_exp;
  assign wi = csel - SW'(1);
  assign ei = exp_sel - SW'(1);
  assign cwr_ok = cwr && int'(csel) >= 1 && int'(csel) <= NBANK;
  assign crd_ok = crd && int'(csel) >= 1 && int'(csel) <= NBANK;
  assign exp_ok = exp_we && int'(exp_sel) >= 1 && int'(exp_sel) <= NBANK;
  assign len = BANK_LEN[int'(bank)*(AW+1) +: AW+1];
  assign err_cnt = cnt;
  // lowest written bank overall and lowest written bank above the current scan bank
  always_comb begin
    first_b = '0;
    first_ok = 1'b0;
    nxt_b = '0;
    nxt_ok = 1'b0;
    for (int i = NBANK - 1; i >= 0; i--) begin
      if (written[i]) begin
        first_b = SW'(i);
        first_ok = 1'b1;
      end
      if (written[i] && i > int'(bank)) begin
        nxt_b = SW'(i);
        nxt_ok = 1'b1;
      end
    end
  end
  // storage arrays and the scan read stage; contents survive reset
  always_ff @(posedge clk) begin
    if (cwr_ok) mem[wi][caddr_wr] <= cdata_wr;
    if (exp_ok) expm[ei][exp_addr] <= exp_data;
    p_mem <= mem[bank][addr];
    p_exp <= expm[bank][addr];
    p_bank <= bank;
    p_addr <= addr;
  end
  // host read port, status flags, mismatch accounting and scan sequencing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cdata_rd <= '0;
      chk_busy <= 1'b0;
      chk_done <= 1'b0;
      written <= '0;
      cnt <= '0;
      first_err_vld <= 1'b0;
      first_err_bank <= '0;
      first_err_addr <= '0;
      proto_err <= 1'b0;
      st <= IDLE;
      bank <= '0;
      addr <= '0;
      issuing <= 1'b0;
      p_vld <= 1'b0;
    end else begin
      if (crd_ok) cdata_rd <= mem[wi][caddr_rd];
      if (cwr_ok) written[wi] <= 1'b1;
      if ((cwr || crd || exp_we) && chk_busy) proto_err <= 1'b1;
      if (p_vld && p_mem != p_exp) begin
        if (cnt[p_bank] != '1) cnt[p_bank] <= cnt[p_bank] + ERRW'(1);
        if (!first_err_vld) begin
          first_err_vld <= 1'b1;
          first_err_bank <= p_bank + SW'(1);
          first_err_addr <= p_addr;
        end
      end
      chk_done <= 1'b0;
      case (st)
        IDLE: if (chk_start && !clr) begin
          st <= SCAN;
          chk_busy <= 1'b1;
          bank <= first_b;
          addr <= '0;
          issuing <= first_ok;
        end
        SCAN: begin
          p_vld <= issuing;
          if (issuing) begin
            if ({1'b0, addr} == len - (AW+1)'(1)) begin
              addr <= '0;
              bank <= nxt_b;
              issuing <= nxt_ok;
            end else addr <= addr + AW'(1);
          end else begin
            st <= DONE;
            chk_busy <= 1'b0;
            chk_done <= 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
      if (clr && !chk_busy) begin
        written <= '0;
        cnt <= '0;
        first_err_vld <= 1'b0;
        first_err_bank <= '0;
        first_err_addr <= '0;
        proto_err <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_conv_layer_mem_chk.sv
// tb_conv_layer_mem_chk: vector table, random traffic and scan checks against a bank-level model
module tb_conv_layer_mem_chk;
  localparam int DW = 20, AW = 12, SW = 3, NB = 5, ERRW = 13;
  logic clk = 0, reset = 1;
  logic cwr = 0, crd = 0, exp_we = 0, clr = 0, chk_start = 0;
  logic [AW-1:0] caddr_wr = 0, caddr_rd = 0, exp_addr = 0;
  logic [DW-1:0] cdata_wr = 0, exp_data = 0, cdata_rd;
  logic [SW-1:0] csel = 0, exp_sel = 0, first_err_bank;
  logic chk_busy, chk_done, first_err_vld, proto_err;
  logic [NB-1:0] written;
  logic [NB*ERRW-1:0] err_cnt;
  logic [AW-1:0] first_err_addr;

  conv_layer_mem_chk dut (
    .clk(clk), .reset(reset), .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
    .exp_we(exp_we), .exp_sel(exp_sel), .exp_addr(exp_addr), .exp_data(exp_data),
    .clr(clr), .chk_start(chk_start), .chk_busy(chk_busy), .chk_done(chk_done),
    .written(written), .err_cnt(err_cnt), .first_err_vld(first_err_vld),
    .first_err_bank(first_err_bank), .first_err_addr(first_err_addr), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit w;
    bit r;
    logic [SW-1:0] sel;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] erd;
    logic [NB-1:0] ewr;
  } vec_t;

  int blen[NB] = '{4096, 4096, 1024, 1024, 2048};
  logic [DW-1:0] m_mem [NB][4096];
  logic [DW-1:0] m_exp [NB][4096];
  logic [NB-1:0] m_wr = 0;
  logic [DW-1:0] m_rd = 0;
  int errors = 0, checks = 0;
  vec_t tbl[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  function automatic bit ok_sel(input logic [SW-1:0] s);
    return s >= 1 && int'(s) <= NB;
  endfunction

  task automatic op(input bit w, input bit r, input logic [SW-1:0] sel, input logic [AW-1:0] wa,
                    input logic [AW-1:0] ra, input logic [DW-1:0] wd, input bit e,
                    input logic [SW-1:0] es, input logic [AW-1:0] ea, input logic [DW-1:0] ed);
    cwr = w; crd = r; csel = sel; caddr_wr = wa; caddr_rd = ra; cdata_wr = wd;
    exp_we = e; exp_sel = es; exp_addr = ea; exp_data = ed;
    step();
    cwr = 0; crd = 0; exp_we = 0;
    if (r && ok_sel(sel)) m_rd = m_mem[sel-1][ra];
    if (w && ok_sel(sel)) begin
      m_mem[sel-1][wa] = wd;
      m_wr[sel-1] = 1'b1;
    end
    if (e && ok_sel(es)) m_exp[es-1][ea] = ed;
  endtask

  task automatic do_clr();
    clr = 1;
    step();
    clr = 0;
    m_wr = 0;
  endtask

  task automatic run_scan(input int exp_busy, input string nm);
    int n = 0;
    chk_start = 1;
    step();
    chk_start = 0;
    while (chk_busy && n < 20000) begin
      n++;
      step();
    end
    chk({nm, " busy cycles"}, 64'(n), 64'(exp_busy));
    chk({nm, " done pulse"}, 64'(chk_done), 64'(1));
    step();
    chk({nm, " done drop"}, 64'(chk_done), 64'(0));
  endtask

  function automatic int model_busy();
    int s = 1;
    for (int b = 0; b < NB; b++) if (m_wr[b]) s += blen[b];
    return s;
  endfunction

  task automatic check_model(input string nm);
    int c[NB];
    bit fv = 0;
    int fb = 0, fa = 0;
    for (int b = 0; b < NB; b++) begin
      c[b] = 0;
      if (m_wr[b])
        for (int a = 0; a < blen[b]; a++)
          if (m_mem[b][a] != m_exp[b][a]) begin
            if (c[b] < 8191) c[b]++;
            if (!fv) begin fv = 1; fb = b + 1; fa = a; end
          end
    end
    for (int b = 0; b < NB; b++)
      chk($sformatf("%s err_cnt[%0d]", nm, b), 64'(err_cnt[b*ERRW +: ERRW]), 64'(c[b]));
    chk({nm, " first_err_vld"}, 64'(first_err_vld), 64'(fv));
    chk({nm, " first_err_bank"}, 64'(first_err_bank), 64'(fb));
    chk({nm, " first_err_addr"}, 64'(first_err_addr), 64'(fa));
  endtask

  initial begin
    logic [DW-1:0] v;
    tbl[0] = '{1, 0, 3'd1, 12'd5, 20'h00ABC, 20'h00000, 5'b00001};
    tbl[1] = '{0, 1, 3'd1, 12'd5, 20'h00000, 20'h00ABC, 5'b00001};
    tbl[2] = '{1, 0, 3'd3, 12'd7, 20'h00001, 20'h00ABC, 5'b00101};
    tbl[3] = '{1, 1, 3'd3, 12'd7, 20'h12345, 20'h00001, 5'b00101};
    tbl[4] = '{0, 1, 3'd3, 12'd7, 20'h00000, 20'h12345, 5'b00101};
    tbl[5] = '{1, 0, 3'd0, 12'd5, 20'h11111, 20'h12345, 5'b00101};
    tbl[6] = '{1, 0, 3'd6, 12'd5, 20'h22222, 20'h12345, 5'b00101};
    tbl[7] = '{0, 1, 3'd0, 12'd5, 20'h00000, 20'h12345, 5'b00101};
    tbl[8] = '{0, 1, 3'd7, 12'd7, 20'h00000, 20'h12345, 5'b00101};
    tbl[9] = '{0, 1, 3'd1, 12'd5, 20'h00000, 20'h00ABC, 5'b00101};
    repeat (2) step();
    chk("rst cdata_rd", 64'(cdata_rd), 0);
    chk("rst chk_busy", 64'(chk_busy), 0);
    chk("rst chk_done", 64'(chk_done), 0);
    chk("rst written", 64'(written), 0);
    chk("rst err_cnt", 64'(err_cnt), 0);
    chk("rst first_err", {first_err_vld, first_err_bank, first_err_addr}, 0);
    chk("rst proto_err", 64'(proto_err), 0);
    reset = 0;
    step();
    for (int i = 0; i < 10; i++) begin
      op(tbl[i].w, tbl[i].r, tbl[i].sel, tbl[i].a, tbl[i].a, tbl[i].d, 0, 0, 0, 0);
      chk($sformatf("vec%0d cdata_rd", i), 64'(cdata_rd), 64'(tbl[i].erd));
      chk($sformatf("vec%0d written", i), 64'(written), 64'(tbl[i].ewr));
    end
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < blen[b]; a++) begin
        v = DW'($urandom);
        op(1, 0, SW'(b + 1), AW'(a), 0, v, 1, SW'(b + 1), AW'(a), v);
      end
    chk("fill written", 64'(written), 64'(5'b11111));
    run_scan(12289, "clean");
    chk("clean err_cnt", 64'(err_cnt), 0);
    chk("clean first_err_vld", 64'(first_err_vld), 0);
    do_clr();
    for (int b = 0; b < NB; b++)
      if (b != 3) op(1, 0, SW'(b + 1), 0, 0, m_exp[b][0], 0, 0, 0, 0);
    op(1, 0, 3'd4, 12'd10, 0, ~m_exp[3][10], 0, 0, 0, 0);
    op(1, 0, 3'd4, 12'd1000, 0, ~m_exp[3][1000], 0, 0, 0, 0);
    op(1, 0, 3'd4, 12'd0, 0, m_exp[3][0], 0, 0, 0, 0);
    run_scan(12289, "corrupt");
    chk("corrupt err_cnt[3]", 64'(err_cnt[3*ERRW +: ERRW]), 2);
    chk("corrupt first bank", 64'(first_err_bank), 4);
    chk("corrupt first addr", 64'(first_err_addr), 10);
    check_model("corrupt");
    do_clr();
    for (int i = 0; i < 400; i++) begin
      logic [SW-1:0] s;
      bit r;
      s = SW'($urandom_range(0, 7));
      r = 1'($urandom_range(0, 1));
      op(1'($urandom_range(0, 1)), r, s, AW'($urandom_range(0, 1023)), AW'($urandom_range(0, 1023)),
         DW'($urandom), 1'($urandom_range(0, 1)), SW'($urandom_range(0, 7)),
         AW'($urandom_range(0, 1023)), DW'($urandom));
      if (r) chk($sformatf("rand%0d cdata_rd", i), 64'(cdata_rd), 64'(m_rd));
    end
    chk("rand written", 64'(written), 64'(m_wr));
    run_scan(model_busy(), "rand");
    check_model("rand");
    do_clr();
    op(1, 0, 3'd5, 0, 0, m_mem[4][0], 0, 0, 0, 0);
    run_scan(2049, "bank5");
    chk("bank5 written", 64'(written), 64'(5'b10000));
    chk("bank5 low err_cnt", 64'(err_cnt[4*ERRW-1:0]), 0);
    check_model("bank5");
    chk_start = 1;
    step();
    chk_start = 0;
    repeat (100) step();
    chk("mid busy", 64'(chk_busy), 1);
    reset = 1;
    #1;
    chk("abort busy", 64'(chk_busy), 0);
    chk("abort err_cnt", 64'(err_cnt), 0);
    chk("abort first_err_vld", 64'(first_err_vld), 0);
    step();
    reset = 0;
    m_wr = 0;
    m_rd = 0;
    step();
    chk("abort written", 64'(written), 0);
    chk("abort cdata_rd", 64'(cdata_rd), 0);
    for (int b = 0; b < NB; b++) begin
      op(0, 1, SW'(b + 1), 0, AW'(b * 37 + 3), 0, 0, 0, 0, 0);
      chk($sformatf("keep bank%0d", b), 64'(cdata_rd), 64'(m_rd));
    end
    op(1, 0, 3'd0, 12'd9, 0, 20'h0F0F0, 0, 0, 0, 0);
    op(1, 0, 3'd6, 12'd9, 0, 20'h0F0F0, 0, 0, 0, 0);
    chk("bad csel written", 64'(written), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
